// File: rtl/enemy_missile_arbiter.sv
// Enemy missile slot arbiter: once per frame binds at most one requesting enemy
// (round-robin) to the lowest free missile slot, paced by a per-level cooldown.
module enemy_missile_arbiter #(
  parameter int N_REQ   = 8,
  parameter int N_SLOT  = 5,
  parameter int CD_BASE = 60,
  parameter int CD_STEP = 4,
  parameter int CD_MIN  = 12
) (
  input  logic                  pclk,
  input  logic                  rst_n,
  input  logic                  frame_tick,
  input  logic [3:0]            level,
  input  logic                  level_change,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_SLOT-1:0]     slot_done,
  output logic [N_REQ-1:0]      grant,
  output logic [N_SLOT-1:0]     slot_launch,
  output logic [N_SLOT-1:0]     slot_busy,
  output logic [3*N_SLOT-1:0]   slot_owner,
  output logic [1:0]            state_dbg
);

  localparam int OW = 3;
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int SW = (N_SLOT > 1) ? $clog2(N_SLOT) : 1;

  localparam logic [1:0] COOL  = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]    state;
  logic [7:0]    cooldown;
  logic [PW-1:0] rr_ptr;

  // Cooldown reload, clamped at zero before the floor so high levels never wrap.
  logic [11:0] cd_prod, cd_diff, cd_clamped;
  logic [7:0]  cd_load;

  always_comb begin
    cd_prod    = 12'(level) * 12'(CD_STEP);
    cd_diff    = (cd_prod < 12'(CD_BASE)) ? (12'(CD_BASE) - cd_prod) : 12'd0;
    cd_clamped = (cd_diff < 12'(CD_MIN)) ? 12'(CD_MIN) : cd_diff;
    cd_load    = cd_clamped[7:0];
  end

  logic          win_found;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] scan_idx;

  // NOTE: every combinational output gets a default before the loop, so no
  // path leaves a value held and no latch is inferred.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      scan_idx = PW'((int'(rr_ptr) + i) % N_REQ);
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  logic          slot_found;
  logic [SW-1:0] slot_idx;

  always_comb begin
    slot_found = 1'b0;
    slot_idx   = '0;
    for (int i = 0; i < N_SLOT; i++) begin
      if (!slot_found && !slot_busy[i]) begin
        slot_found = 1'b1;
        slot_idx   = SW'(i);
      end
    end
  end

  // A slot finishing in the decision cycle still counts as busy for that decision.
  logic                do_grant;
  logic [N_REQ-1:0]    grant_onehot;
  logic [N_SLOT-1:0]   launch_onehot;
  logic [PW-1:0]       rr_next;

  always_comb begin
    do_grant      = frame_tick && !level_change && (state == ARMED) && win_found && slot_found;
    grant_onehot  = N_REQ'(1) << win_idx;
    launch_onehot = N_SLOT'(1) << slot_idx;
    rr_next       = (int'(win_idx) == N_REQ - 1) ? '0 : win_idx + PW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments only; later
  // assignments in the same block override the defaults at the top.
  // NOTE: slot_owner is a small register bank, so it is reset with the rest.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= COOL;
      cooldown    <= 8'(CD_BASE);
      rr_ptr      <= '0;
      grant       <= '0;
      slot_launch <= '0;
      slot_busy   <= '0;
      slot_owner  <= '0;
    end else begin
      grant       <= '0;
      slot_launch <= '0;
      slot_busy   <= slot_busy & ~slot_done;
      if (level_change) begin
        slot_busy <= '0;
        rr_ptr    <= '0;
        cooldown  <= cd_load;
        state     <= HOLD;
      end else if (frame_tick) begin
        case (state)
          COOL: begin
            if (cooldown > 8'd1) begin
              cooldown <= cooldown - 8'd1;
            end else begin
              cooldown <= 8'd0;
              state    <= ARMED;
            end
          end
          ARMED: begin
            if (do_grant) begin
              grant                          <= grant_onehot;
              slot_launch                    <= launch_onehot;
              slot_busy                      <= (slot_busy & ~slot_done) | launch_onehot;
              slot_owner[OW*slot_idx +: OW]  <= OW'(win_idx);
              rr_ptr                         <= rr_next;
              cooldown                       <= cd_load;
              state                          <= COOL;
            end
          end
          HOLD:    state <= COOL;
          default: state <= COOL;
        endcase
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_enemy_missile_arbiter.sv
// Scoreboard bench for enemy_missile_arbiter: directed frame sequences push the
// expected grants, a negedge monitor pops and compares every launch pulse.
module tb_enemy_missile_arbiter;

  logic        pclk = 1'b0;
  logic        rst_n;
  logic        frame_tick;
  logic [3:0]  level;
  logic        level_change;
  logic [7:0]  req;
  logic [4:0]  slot_done;
  logic [7:0]  grant;
  logic [4:0]  slot_launch;
  logic [4:0]  slot_busy;
  logic [14:0] slot_owner;
  logic [1:0]  state_dbg;

  enemy_missile_arbiter dut (
    .pclk        (pclk),
    .rst_n       (rst_n),
    .frame_tick  (frame_tick),
    .level       (level),
    .level_change(level_change),
    .req         (req),
    .slot_done   (slot_done),
    .grant       (grant),
    .slot_launch (slot_launch),
    .slot_busy   (slot_busy),
    .slot_owner  (slot_owner),
    .state_dbg   (state_dbg)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [7:0] g;
    logic [4:0] sl;
    int         slot;
    logic [2:0] own;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every launch pulse the DUT presents must match the next expectation.
  always @(negedge pclk) begin
    if (rst_n === 1'b1 && (grant !== 8'd0 || slot_launch !== 5'd0)) begin
      if (q.size() == 0) begin
        check("unexpected_pulse", 32'({grant, slot_launch}), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("grant", 32'(grant), 32'(e.g));
        check("slot_launch", 32'(slot_launch), 32'(e.sl));
        check("slot_owner", 32'(slot_owner[e.slot*3 +: 3]), 32'(e.own));
        check("slot_busy_bit", 32'(slot_busy[e.slot]), 32'd1);
      end
    end
  end

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic tick(input logic lc, input logic [4:0] done);
    frame_tick   = 1'b1;
    level_change = lc;
    slot_done    = done;
    @(posedge pclk); #1;
    frame_tick   = 1'b0;
    level_change = 1'b0;
    slot_done    = '0;
    @(posedge pclk); #1;
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 5'd0);
  endtask

  task automatic grant_tick(input logic [7:0] g, input int slot, input logic [2:0] own,
                            input logic [4:0] done);
    exp_t e;
    e.g    = g;
    e.sl   = 5'(1 << slot);
    e.slot = slot;
    e.own  = own;
    q.push_back(e);
    tick(1'b0, done);
    check("grant_missing", 32'(q.size()), 32'd0);
  endtask

  task automatic pulse_done(input logic [4:0] done);
    slot_done = done;
    @(posedge pclk); #1;
    slot_done = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    frame_tick   = 1'b0;
    level        = 4'd0;
    level_change = 1'b0;
    req          = 8'b0000_0100;
    slot_done    = '0;
    #3;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_launch", 32'(slot_launch), 32'd0);
    check("rst_busy", 32'(slot_busy), 32'd0);
    check("rst_owner", 32'(slot_owner), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    #19 rst_n = 1'b1;
    @(posedge pclk); #1;

    // First grant after the level-0 cooldown: tick 60 arms, tick 61 grants.
    run_ticks(60);
    check("armed_after_60", 32'(state_dbg), 32'd1);
    grant_tick(8'h04, 0, 3'd2, 5'd0);
    check("busy_first", 32'(slot_busy), 32'b00001);
    check("state_after_grant", 32'(state_dbg), 32'd0);

    // Enemy 6 wins from rr_ptr=3, leaving rr_ptr=7; level 12 loads cooldown 12.
    level = 4'd12;
    req   = 8'h40;
    run_ticks(60);
    grant_tick(8'h40, 1, 3'd6, 5'd0);
    pulse_done(5'b00011);
    check("busy_freed", 32'(slot_busy), 32'd0);

    // Round-robin 7,0,1,2 into slots 0..3, 13 ticks apart.
    req = 8'hFF;
    run_ticks(12); grant_tick(8'h80, 0, 3'd7, 5'd0);
    run_ticks(12); grant_tick(8'h01, 1, 3'd0, 5'd0);
    run_ticks(12); grant_tick(8'h02, 2, 3'd1, 5'd0);
    run_ticks(12); grant_tick(8'h04, 3, 3'd2, 5'd0);
    check("busy_rr", 32'(slot_busy), 32'b01111);

    // Level 15 clamps to the floor of 12; fill the last slot.
    level = 4'd15;
    run_ticks(12); grant_tick(8'h08, 4, 3'd3, 5'd0);
    check("busy_full", 32'(slot_busy), 32'b11111);

    // Pool full: armed but no pulse until a slot frees.
    run_ticks(12);
    check("armed_full", 32'(state_dbg), 32'd1);
    run_ticks(3);
    check("still_armed", 32'(state_dbg), 32'd1);
    tick(1'b0, 5'b01000);
    check("busy_after_done3", 32'(slot_busy), 32'b10111);
    grant_tick(8'h10, 3, 3'd4, 5'b00001);
    check("busy_launch_and_done", 32'(slot_busy), 32'b11110);

    // level_change on a would-be granting tick suppresses the grant.
    run_ticks(12);
    check("armed_before_lc", 32'(state_dbg), 32'd1);
    level = 4'd0;
    tick(1'b1, 5'd0);
    check("lc_busy_clear", 32'(slot_busy), 32'd0);
    check("lc_state_hold", 32'(state_dbg), 32'd2);
    tick(1'b0, 5'd0);
    check("hold_to_cool", 32'(state_dbg), 32'd0);
    run_ticks(60);
    check("armed_after_reload", 32'(state_dbg), 32'd1);
    req = 8'h00;
    tick(1'b0, 5'd0);
    check("armed_no_req", 32'(state_dbg), 32'd1);
    req = 8'hFF;
    grant_tick(8'h01, 0, 3'd0, 5'd0);
    check("busy_after_lc_grant", 32'(slot_busy), 32'b00001);

    // Reset asserted while grant is high.
    run_ticks(60);
    frame_tick = 1'b1;
    @(posedge pclk); #1;
    frame_tick = 1'b0;
    check("pre_reset_grant", 32'(grant), 32'h02);
    check("pre_reset_launch", 32'(slot_launch), 32'b00010);
    #1 rst_n = 1'b0;
    #1;
    check("async_grant_clear", 32'(grant), 32'd0);
    check("async_launch_clear", 32'(slot_launch), 32'd0);
    check("async_busy_clear", 32'(slot_busy), 32'd0);
    #10 rst_n = 1'b1;
    repeat (3) @(posedge pclk);
    #1;
    check("post_reset_outputs", 32'({grant, slot_launch, slot_busy}), 32'd0);
    check("post_reset_owner", 32'(slot_owner), 32'd0);
    check("post_reset_state", 32'(state_dbg), 32'd0);

    check("queue_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
